fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipeline; successor to the fixed two-source, MEM/WB-only forwarding logic.
- Tracks every in-flight register writer in a DEPTH-slot shift register. Slot 1 = EX, slot 2 = MEM, slot 3 = WB, and so on.
- Each writer carries its own result latency, so ALU, load and multi-cycle units share one mechanism.
- Checks the NUM_SRC sources of the instruction in ID. Raises a load-use/latency stall, or registers per-source forward selects that the EX-stage operand muxes use on the next cycle.

Parameters:
- NUM_SRC, 3, source operands checked per instruction (rs1, rs2, store data).
- REG_AW, 5, register address width.
- DEPTH, 4, tracked slots after ID; slot DEPTH is the last stage with a forward path.
- LAT_W, 2, width of the result-latency field.
- SEL_W, $clog2(DEPTH+1), forward-select width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall_in  in  1  global freeze (e.g. memory wait); all state holds.
- flush  in  1  the ID instruction is squashed and not recorded.
- issue_valid  in  1  an instruction is in ID.
- issue_we  in  1  the ID instruction writes a register.
- issue_waddr  in  REG_AW  destination register.
- issue_lat  in  LAT_W  result latency: 1 = ALU, 2 = load, up to 2^LAT_W-1 = multi-cycle.
- src_addr  in  NUM_SRC*REG_AW  packed source addresses; source i is at bits [i*REG_AW +: REG_AW].
- src_use  in  NUM_SRC  per-source use bits.
- hazard_stall  out  1  combinational; ID must hold and a bubble enters EX.
- fwd_sel  out  NUM_SRC*SEL_W  registered, valid while the consumer is in EX. 0 = register file; k = forward from slot k.

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst is synchronous and active-high.
- Reset state: all slot valid bits 0; fwd_sel 0. After reset, hazard_stall is 0 until a match exists.
- Slot entry fields: valid, waddr, rdy = issue_lat + 1. rdy is the slot index from which the result can be forwarded.
- Source match: slot j matches source i when all of the following hold:
  - slot j valid;
  - waddr != 0 and waddr == src_addr[i];
  - src_use[i] = 1;
  - issue_valid = 1.
  - The youngest (lowest j) matching slot wins. Older matches are ignored.
- Readiness: a source is ready if it has no match, or if its youngest match has j+1 >= rdy (the producer advances one slot before the consumer reaches EX). Otherwise the source is blocked.
- hazard_stall = issue_valid & ~flush & (any source blocked). Not gated by stall_in.
- Per-cycle update, first matching case wins:
  - rst: clear everything.
  - stall_in: all slots and fwd_sel hold.
  - Otherwise, slots shift j -> j+1 and slot DEPTH is discarded; the value is then in the register file.
    - Slot 1 loads {issue_we & issue_valid & ~flush & ~hazard_stall, issue_waddr, issue_lat+1}; otherwise slot 1 loads a bubble (valid = 0).
    - fwd_sel[i] loads (youngest match j)+1 if a match exists and the instruction issues (no stall, no flush); otherwise fwd_sel[i] loads 0.
- Writers: instructions with issue_we = 0, or with destination x0, occupy a slot with valid = 0.
- Latency limit: if issue_lat+1 > DEPTH, the consumer stalls until the producer leaves slot DEPTH. It then reads the register file (fwd_sel = 0).
- Simultaneous flush and hazard: flush wins. hazard_stall = 0 and a bubble enters slot 1.
- Reset mid-operation discards all in-flight tracking.

Optional Feature:
- Macro FWD_SCOREBOARD_STATS_EN.
- When defined, adds output stall_cnt (32 bits), reset to 0. It increments by 1 in every cycle with hazard_stall & ~stall_in, and saturates at 0xFFFFFFFF.
- When undefined, the port and counter are absent and the remaining behaviour is identical.

Test Plan:
- ALU chain: issue x5 = ALU (lat 1), then an instruction using rs1 = x5 -> no stall; next cycle fwd_sel[0] = 2.
- Load-use: load x6 (lat 2), then use x6 -> hazard_stall = 1 for exactly 1 cycle; the bubble enters slot 1; then fwd_sel = 3. With the stats macro, stall_cnt = 1.
- Youngest wins: ALU x7, ALU x7, then use x7 -> fwd_sel = 2 (not 3). With a load x7 as the youngest producer and an ALU x7 older, the consumer stalls 1 cycle.
- x0 and unused sources: writer of x0 and consumer of x0, plus src_use = 0 on a matching address -> no stall, fwd_sel = 0.
- stall_in during a load-use stall: hold stall_in 3 cycles -> slots and fwd_sel frozen and hazard_stall remains 1. After release, the sequence completes as in the load-use case.
- Multi-cycle and flush:
  - issue_lat = 3 with DEPTH = 4: a dependent instruction stalls 2 cycles, then fwd_sel = 4.
  - flush while the ID instruction has a hazard: hazard_stall = 0, the instruction is not recorded, and a later user of its destination sees no match.
  - rst mid-stream: all fwd_sel = 0 and no stall on the next cycle.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: parametrised forwarding and hazard unit.
//
// Every in-flight register writer is tracked in a DEPTH-slot shift register
// (slot 1 = EX, slot 2 = MEM, slot 3 = WB, ...). Each entry records its
// destination and the slot index from which its result can be forwarded
// (rdy = issue_lat + 1). The NUM_SRC sources of the instruction in ID are
// compared against the slots. The unit either raises a combinational stall
// or registers per-source forward selects for the EX-stage operand muxes.
//
// Optional feature: define FWD_SCOREBOARD_STATS_EN to add a saturating
// 32-bit stall_cnt output that counts cycles with hazard_stall & ~stall_in.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   stall_in      global freeze; slots and fwd_sel hold
//   flush         ID instruction is squashed and not recorded
//   issue_valid   an instruction is in ID
//   issue_we      ID instruction writes a register
//   issue_waddr   destination register
//   issue_lat     result latency (1 = ALU, 2 = load, ...)
//   src_addr      packed source addresses, source i at [i*REG_AW +: REG_AW]
//   src_use       per-source use bits
//   hazard_stall  combinational; ID holds and a bubble enters EX
//   fwd_sel       registered per-source select: 0 = regfile, k = slot k
//   stall_cnt     (FWD_SCOREBOARD_STATS_EN only) saturating stall counter
module fwd_scoreboard #(
  parameter int NUM_SRC = 3,
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 4,
  parameter int LAT_W   = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_in,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic                      issue_we,
  input  logic [REG_AW-1:0]         issue_waddr,
  input  logic [LAT_W-1:0]          issue_lat,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_use,
  output logic                      hazard_stall,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int RDY_W = LAT_W + 1;
  localparam int CMP_W = ((SEL_W > RDY_W) ? SEL_W : RDY_W) + 1;

  logic [DEPTH:1]    slot_valid_r;
  logic [REG_AW-1:0] slot_waddr_r [1:DEPTH];
  logic [RDY_W-1:0]  slot_rdy_r   [1:DEPTH];

  logic                     hit_s;
  logic [NUM_SRC-1:0]       found_s;
  logic [NUM_SRC-1:0]       blocked_s;
  logic [SEL_W-1:0]         match_slot_s [NUM_SRC];
  logic [RDY_W-1:0]         match_rdy_s  [NUM_SRC];
  logic [NUM_SRC*SEL_W-1:0] fwd_next_s;
  logic                     issue_s;
  logic                     new_valid_s;
  logic [RDY_W-1:0]         new_rdy_s;

  // Youngest-match search, readiness, stall decision and next forward selects
  always_comb begin
    hit_s       = 1'b0;
    found_s     = {NUM_SRC{1'b0}};
    blocked_s   = {NUM_SRC{1'b0}};
    fwd_next_s  = {(NUM_SRC*SEL_W){1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      match_slot_s[i] = {SEL_W{1'b0}};
      match_rdy_s[i]  = {RDY_W{1'b0}};
      // Scan oldest to youngest so the lowest matching slot is the one kept.
      for (int j = DEPTH; j >= 1; j--) begin
        hit_s = slot_valid_r[j] && (slot_waddr_r[j] != {REG_AW{1'b0}}) &&
                (slot_waddr_r[j] == src_addr[i*REG_AW +: REG_AW]) &&
                src_use[i] && issue_valid;
        found_s[i]      = found_s[i] | hit_s;
        match_slot_s[i] = hit_s ? SEL_W'(j) : match_slot_s[i];
        match_rdy_s[i]  = hit_s ? slot_rdy_r[j] : match_rdy_s[i];
      end
      // The producer advances one slot before the consumer reaches EX.
      // A result that only appears beyond slot DEPTH has no forward path,
      // so the consumer waits until it is in the register file.
      blocked_s[i] = found_s[i] &&
                     (((CMP_W'(match_slot_s[i]) + CMP_W'(1)) < CMP_W'(match_rdy_s[i])) ||
                      (CMP_W'(match_rdy_s[i]) > CMP_W'(DEPTH)));
    end
    hazard_stall = issue_valid & ~flush & (|blocked_s);
    issue_s      = issue_valid & ~flush & ~hazard_stall;
    new_valid_s  = issue_s & issue_we & (issue_waddr != {REG_AW{1'b0}});
    new_rdy_s    = RDY_W'(issue_lat) + RDY_W'(1);
    for (int i = 0; i < NUM_SRC; i++) begin
      // A match in slot DEPTH retires this cycle; EX then reads the regfile.
      fwd_next_s[i*SEL_W +: SEL_W] =
        (issue_s && found_s[i] && (match_slot_s[i] < SEL_W'(DEPTH))) ?
        (match_slot_s[i] + SEL_W'(1)) : {SEL_W{1'b0}};
    end
  end

  // Slot shift register and registered forward selects
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_r <= {DEPTH{1'b0}};
      for (int j = 1; j <= DEPTH; j++) begin
        slot_waddr_r[j] <= {REG_AW{1'b0}};
        slot_rdy_r[j]   <= {RDY_W{1'b0}};
      end
      fwd_sel <= {(NUM_SRC*SEL_W){1'b0}};
    end else if (!stall_in) begin
      for (int j = DEPTH; j >= 2; j--) begin
        slot_valid_r[j] <= slot_valid_r[j-1];
        slot_waddr_r[j] <= slot_waddr_r[j-1];
        slot_rdy_r[j]   <= slot_rdy_r[j-1];
      end
      slot_valid_r[1] <= new_valid_s;
      slot_waddr_r[1] <= issue_waddr;
      slot_rdy_r[1]   <= new_rdy_s;
      fwd_sel         <= fwd_next_s;
    end
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  // Saturating count of cycles lost to hazards while the pipe is moving
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (hazard_stall && !stall_in && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard (default parameters).
// A list of in-flight writers tagged with their age in pipeline steps is the
// reference; directed scenarios pin it with literal expectations and a long
// randomized run compares the DUT against it every cycle.
module tb_fwd_scoreboard;

  localparam int NS = 3;
  localparam int AW = 5;
  localparam int D  = 4;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_in;
  logic              flush;
  logic              issue_valid;
  logic              issue_we;
  logic [AW-1:0]     issue_waddr;
  logic [1:0]        issue_lat;
  logic [NS*AW-1:0]  src_addr;
  logic [NS-1:0]     src_use;
  logic              hazard_stall;
  logic [NS*SW-1:0]  fwd_sel;
`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0]       stall_cnt;
`endif

  fwd_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .stall_in     (stall_in),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_waddr  (issue_waddr),
    .issue_lat    (issue_lat),
    .src_addr     (src_addr),
    .src_use      (src_use),
    .hazard_stall (hazard_stall),
    .fwd_sel      (fwd_sel)
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference: writers still in flight, age = pipeline steps since issue.
  typedef struct {
    int waddr;
    int lat;
    int age;
  } wr_t;

  wr_t         q[$];
  int          m_fwd[NS];
  logic [31:0] m_cnt;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fs(input int i);
    return {29'd0, fwd_sel[i*SW +: SW]};
  endfunction

  // One clock: drive inputs, check the stall on the falling edge, advance the
  // reference at the rising edge, then check the registered outputs.
  task automatic cyc(input bit r, input bit si, input bit fl, input bit iv,
                     input bit iw, input int wa, input int lt,
                     input int a0, input int a1, input int a2,
                     input bit [2:0] su, output bit hz);
    int a[NS];
    bit fnd[NS];
    int best_age[NS];
    int best_lat[NS];
    int nf[NS];
    bit blk;
    bit m_hz;
    bit iss;
    a[0] = a0; a[1] = a1; a[2] = a2;
    rst = r; stall_in = si; flush = fl; issue_valid = iv; issue_we = iw;
    issue_waddr = wa[4:0]; issue_lat = lt[1:0];
    src_addr = {a2[4:0], a1[4:0], a0[4:0]}; src_use = su;
    @(negedge clk);
    blk = 1'b0;
    for (int i = 0; i < NS; i++) begin
      fnd[i] = 1'b0; best_age[i] = 0; best_lat[i] = 0;
      if (iv && su[i] && a[i] != 0) begin
        foreach (q[k]) begin
          if (q[k].waddr == a[i] && (!fnd[i] || q[k].age < best_age[i])) begin
            fnd[i] = 1'b1; best_age[i] = q[k].age; best_lat[i] = q[k].lat;
          end
        end
      end
      // The result exists once the producer is lat steps past EX entry, and
      // only if that point is still inside the tracked window.
      if (fnd[i] && (best_age[i] < best_lat[i] || best_lat[i] + 1 > D)) blk = 1'b1;
    end
    m_hz = iv && !fl && blk;
    chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, m_hz});
    hz  = hazard_stall;
    iss = iv && !fl && !m_hz;
    for (int i = 0; i < NS; i++)
      nf[i] = (iss && fnd[i] && best_age[i] < D) ? best_age[i] + 1 : 0;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      for (int i = 0; i < NS; i++) m_fwd[i] = 0;
      m_cnt = 32'd0;
    end else begin
      if (!si) begin
        foreach (q[k]) q[k].age++;
        for (int k = q.size() - 1; k >= 0; k--)
          if (q[k].age > D) q.delete(k);
        if (iss && iw && wa != 0) q.push_front('{waddr: wa, lat: lt, age: 1});
        for (int i = 0; i < NS; i++) m_fwd[i] = nf[i];
      end
      if (m_hz && !si && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    for (int i = 0; i < NS; i++) chk($sformatf("fwd_sel[%0d]", i), fs(i), m_fwd[i]);
`ifdef FWD_SCOREBOARD_STATS_EN
    chk("stall_cnt", stall_cnt, m_cnt);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    n_cmp = 0; n_bad = 0; m_cnt = 32'd0;
    for (int i = 0; i < NS; i++) m_fwd[i] = 0;
    rst = 1'b1; stall_in = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_we = 1'b0;
    issue_waddr = 5'd0; issue_lat = 2'd0; src_addr = 15'd0; src_use = 3'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, h);
    chk("reset_fwd", {23'd0, fwd_sel}, 32'd0);
    cyc(0, 0, 0, 1, 0, 0, 0, 5, 6, 7, 3'b111, h);
    chk("reset_nostall", {31'd0, h}, 32'd0);

    // ALU chain
    cyc(0, 0, 0, 1, 1, 5, 1, 0, 0, 0, 3'b000, h);
    cyc(0, 0, 0, 1, 0, 0, 0, 5, 0, 0, 3'b001, h);
    chk("alu_nostall", {31'd0, h}, 32'd0);
    chk("alu_fwd", fs(0), 32'd2);

    // Load-use
    cyc(0, 0, 0, 1, 1, 6, 2, 0, 0, 0, 3'b000, h);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 6, 0, 3'b010, h);
    chk("ld_stall", {31'd0, h}, 32'd1);
    chk("ld_stall_fwd", fs(1), 32'd0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 6, 0, 3'b010, h);
    chk("ld_release", {31'd0, h}, 32'd0);
    chk("ld_fwd", fs(1), 32'd3);

    // Youngest wins (two ALU writers)
    cyc(0, 0, 0, 1, 1, 7, 1, 0, 0, 0, 3'b000, h);
    cyc(0, 0, 0, 1, 1, 7, 1, 0, 0, 0, 3'b000, h);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 7, 3'b100, h);
    chk("young_nostall", {31'd0, h}, 32'd0);
    chk("young_fwd", fs(2), 32'd2);

    // Youngest is a load, older ALU ignored
    cyc(0, 0, 0, 1, 1, 7, 1, 0, 0, 0, 3'b000, h);
    cyc(0, 0, 0, 1, 1, 7, 2, 0, 0, 0, 3'b000, h);
    cyc(0, 0, 0, 1, 0, 0, 0, 7, 0, 0, 3'b001, h);
    chk("young_ld_stall", {31'd0, h}, 32'd1);
    cyc(0, 0, 0, 1, 0, 0, 0, 7, 0, 0, 3'b001, h);
    chk("young_ld_release", {31'd0, h}, 32'd0);
    chk("young_ld_fwd", fs(0), 32'd3);

    // x0 writer/consumer and unused matching source
    cyc(0, 0, 0, 1, 1, 9, 1, 0, 0, 0, 3'b000, h);
    cyc(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 3'b000, h);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 9, 0, 3'b001, h);
    chk("x0_nostall", {31'd0, h}, 32'd0);
    chk("x0_fwd0", fs(0), 32'd0);
    chk("unused_fwd1", fs(1), 32'd0);

    // stall_in during a load-use stall
    cyc(0, 0, 0, 1, 1, 6, 2, 0, 0, 0, 3'b000, h);
    for (int n = 0; n < 3; n++) begin
      cyc(0, 1, 0, 1, 0, 0, 0, 6, 0, 0, 3'b001, h);
      chk("frozen_stall", {31'd0, h}, 32'd1);
    end
    cyc(0, 0, 0, 1, 0, 0, 0, 6, 0, 0, 3'b001, h);
    chk("unfrozen_stall", {31'd0, h}, 32'd1);
    cyc(0, 0, 0, 1, 0, 0, 0, 6, 0, 0, 3'b001, h);
    chk("unfrozen_release", {31'd0, h}, 32'd0);
    chk("unfrozen_fwd", fs(0), 32'd3);

    // Multi-cycle latency 3
    cyc(0, 0, 0, 1, 1, 10, 3, 0, 0, 0, 3'b000, h);
    cyc(0, 0, 0, 1, 0, 0, 0, 10, 0, 0, 3'b001, h);
    chk("mc_stall1", {31'd0, h}, 32'd1);
    cyc(0, 0, 0, 1, 0, 0, 0, 10, 0, 0, 3'b001, h);
    chk("mc_stall2", {31'd0, h}, 32'd1);
    cyc(0, 0, 0, 1, 0, 0, 0, 10, 0, 0, 3'b001, h);
    chk("mc_release", {31'd0, h}, 32'd0);
    chk("mc_fwd", fs(0), 32'd4);

    // Flush beats hazard; flushed writer is not recorded
    cyc(0, 0, 0, 1, 1, 11, 2, 0, 0, 0, 3'b000, h);
    cyc(0, 0, 1, 1, 1, 12, 1, 11, 0, 0, 3'b001, h);
    chk("flush_nostall", {31'd0, h}, 32'd0);
    cyc(0, 0, 0, 1, 0, 0, 0, 12, 0, 0, 3'b001, h);
    chk("flush_nomatch_stall", {31'd0, h}, 32'd0);
    chk("flush_nomatch_fwd", fs(0), 32'd0);

    // Reset mid-stream while a load-use hazard is pending
    cyc(0, 0, 0, 1, 1, 13, 2, 0, 0, 0, 3'b000, h);
    cyc(1, 0, 0, 1, 0, 0, 0, 13, 0, 0, 3'b001, h);
    chk("rst_mid_fwd", {23'd0, fwd_sel}, 32'd0);
    cyc(0, 0, 0, 1, 0, 0, 0, 13, 13, 13, 3'b111, h);
    chk("rst_mid_nostall", {31'd0, h}, 32'd0);
    chk("rst_mid_fwd_after", {23'd0, fwd_sel}, 32'd0);

    // Randomized traffic on a small register set to force frequent matches
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom % 64) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0,
          ($urandom % 4) != 0, ($urandom % 2) == 1, int'($urandom % 8),
          int'($urandom % 4), int'($urandom % 8), int'($urandom % 8),
          int'($urandom % 8), 3'($urandom % 8), h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
